// File: rtl/mult_seq_digit.sv
// Sequential unsigned multiplier. One 2x2 digit product is shift-accumulated per cycle.
// Digit index j is the inner index and i is the outer index. A zero operand skips the digit loop.
module mult_seq_digit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int D  = WIDTH / 2;
  localparam int IW = (D > 1) ? $clog2(D) : 1;

  // ZSKIP is one idle cycle spent on a zero operand, so that product takes a single cycle.
  typedef enum logic [1:0] {IDLE, CALC, ZSKIP, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   reg_a;
  logic [WIDTH-1:0]   reg_b;
  logic [2*WIDTH-1:0] acc;
  logic [IW-1:0]      idx_i;
  logic [IW-1:0]      idx_j;

  logic [1:0]         dig_a;
  logic [1:0]         dig_b;
  logic [3:0]         prod;
  logic [2*WIDTH-1:0] term;
  logic               last_i;
  logic               last_j;

  always_comb begin
    dig_a  = reg_a[2*int'(idx_i) +: 2];
    dig_b  = reg_b[2*int'(idx_j) +: 2];
    prod   = {2'b00, dig_a} * {2'b00, dig_b};
    term   = {{(2*WIDTH-4){1'b0}}, prod} << (2 * (int'(idx_i) + int'(idx_j)));
    last_i = (idx_i == IW'(D - 1));
    last_j = (idx_j == IW'(D - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      reg_a <= '0;
      reg_b <= '0;
      acc   <= '0;
      idx_i <= '0;
      idx_j <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            reg_a <= a;
            reg_b <= b;
            acc   <= '0;
            idx_i <= '0;
            idx_j <= '0;
            state <= ((a == '0) || (b == '0)) ? ZSKIP : CALC;
          end
        end
        CALC: begin
          acc <= acc + term;
          if (last_j) begin
            idx_j <= '0;
            if (last_i) begin
              idx_i <= '0;
              state <= DONE;
            end else begin
              idx_i <= idx_i + IW'(1);
            end
          end else begin
            idx_j <= idx_j + IW'(1);
          end
        end
        ZSKIP: state <= DONE;
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gating with rst_n keeps in_ready low while reset is held.
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC);
  assign p         = acc;

endmodule

// File: tb/tb_mult_seq_digit.sv
// Scoreboard bench for mult_seq_digit with a WIDTH=8 instance and a WIDTH=4 instance.
// The drivers push expected products and latencies. The monitors compare those on out_valid and on consume.
module tb_mult_seq_digit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  mult_seq_digit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .p(p8), .busy(busy8)
  );

  mult_seq_digit #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
    .p(p4), .busy(busy4)
  );

  typedef struct {
    logic [15:0] p;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   busy_seen8, busy_seen4;
  bit   prev_v8 = 1'b0;
  bit   prev_v4 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy8) busy_seen8 = 1'b1;
      if (out_valid8 && !prev_v8) begin
        if (q8.size() == 0) begin
          chk("w8_unexpected_product", p8, -1);
        end else begin
          chk("w8_latency", cyc - q8[0].acc_cyc, q8[0].lat);
          chk("w8_busy_seen", busy_seen8, (q8[0].lat != 1) ? 1 : 0);
        end
      end
      if (out_valid8 && q8.size() > 0) begin
        chk("w8_p", p8, q8[0].p);
        if (out_ready8) void'(q8.pop_front());
      end
    end
    prev_v8 = out_valid8;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy4) busy_seen4 = 1'b1;
      if (out_valid4 && !prev_v4) begin
        if (q4.size() == 0) begin
          chk("w4_unexpected_product", p4, -1);
        end else begin
          chk("w4_latency", cyc - q4[0].acc_cyc, q4[0].lat);
          chk("w4_busy_seen", busy_seen4, (q4[0].lat != 1) ? 1 : 0);
        end
      end
      if (out_valid4 && q4.size() > 0) begin
        chk("w4_p", p4, q4[0].p);
        if (out_ready4) void'(q4.pop_front());
      end
    end
    prev_v4 = out_valid4;
  end

  task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] pe);
    int n = 0;
    exp_t e;
    @(posedge clk);
    #1;
    a8 = a; b8 = b; in_valid8 = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready8 && n < 100);
    if (!in_ready8) begin
      chk("w8_accept_timeout", 0, 1);
      in_valid8 = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    busy_seen8 = 1'b0;
    e.p = pe;
    e.lat = ((a == 0) || (b == 0)) ? 1 : 16;
    e.acc_cyc = cyc;
    q8.push_back(e);
  endtask

  task automatic accept4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] pe);
    int n = 0;
    exp_t e;
    @(posedge clk);
    #1;
    a4 = a; b4 = b; in_valid4 = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready4 && n < 100);
    if (!in_ready4) begin
      chk("w4_accept_timeout", 0, 1);
      in_valid4 = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    busy_seen4 = 1'b0;
    e.p = {8'h00, pe};
    e.lat = ((a == 0) || (b == 0)) ? 1 : 4;
    e.acc_cyc = cyc;
    q4.push_back(e);
  endtask

  task automatic drain8();
    int n = 0;
    while (q8.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0) begin
      chk("w8_drain_timeout", q8.size(), 0);
      q8.delete();
    end
  endtask

  task automatic drain4();
    int n = 0;
    while (q4.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q4.size() != 0) begin
      chk("w4_drain_timeout", q4.size(), 0);
      q4.delete();
    end
  endtask

  logic [7:0]  va [5] = '{8'd13, 8'd255, 8'd170, 8'd0,   8'd200};
  logic [7:0]  vb [5] = '{8'd11, 8'd255, 8'd85,  8'd200, 8'd0};
  logic [15:0] vp [5] = '{16'd143, 16'd65025, 16'd14450, 16'd0, 16'd0};

  initial begin
    int n;
    rst_n = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; out_ready4 = 1'b1;
    #3;
    chk("rst_in_ready8", in_ready8, 0);
    chk("rst_out_valid8", out_valid8, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_p8", p8, 0);
    chk("rst_in_ready4", in_ready4, 0);
    chk("rst_p4", p4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready8", in_ready8, 1);

    for (int k = 0; k < 5; k++) begin
      accept8(va[k], vb[k], vp[k]);
      drain8();
      @(negedge clk);
      chk("w8_in_ready_after_consume", in_ready8, 1);
      chk("w8_out_valid_after_consume", out_valid8, 0);
    end

    // Backpressure, with a competing request held on the inputs.
    out_ready8 = 1'b0;
    accept8(8'd7, 8'd9, 16'd63);
    n = 0;
    while (!out_valid8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", out_valid8, 1);
    @(posedge clk);
    #1;
    a8 = 8'd1; b8 = 8'd1; in_valid8 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid_hold", out_valid8, 1);
      chk("bp_in_ready_low", in_ready8, 0);
      chk("bp_p_hold", p8, 63);
    end
    @(posedge clk);
    #1;
    out_ready8 = 1'b1;
    accept8(8'd1, 8'd1, 16'd1);
    drain8();

    // Abort in the middle of CALC.
    accept8(8'd100, 8'd100, 16'd10000);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("abort_out_valid", out_valid8, 0);
    chk("abort_p", p8, 0);
    chk("abort_busy", busy8, 0);
    chk("abort_in_ready_in_reset", in_ready8, 0);
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready_after", in_ready8, 1);
    chk("abort_p_after", p8, 0);
    repeat (25) @(negedge clk);
    chk("abort_no_product", out_valid8, 0);
    accept8(8'd3, 8'd5, 16'd15);
    drain8();

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        accept4(4'(x), 4'(y), 8'(x * y));
        drain4();
      end
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
